fb_writer: RTL
==============

// Module: fb_writer
// PURPOSE
//  Wishbone write master filling the SDRAM framebuffer that the display controller scans out.
//  - Accepts a 24-bit RGB pixel stream (valid/ready, start-of-frame flag).
//  - Buffers pixels in a small FIFO, then issues classic Wishbone write cycles in short bursts.
//  - Uses the same word layout and address map as the display scan-out, so written frames display unmodified.
// PARAMETERS
//  HDISP     800  active pixels per line
//  VDISP     480  active lines per frame
//  FIFO_AW   4    log2 of FIFO depth (16 entries)
//  BURST     16   max acked writes per cyc assertion (>=1)
// PORTS
//  clk        in   1   single clock (Wishbone clock domain)
//  rst_n      in   1   synchronous, active-low reset
//  pix_valid  in   1   pixel present on pix_rgb/pix_sof
//  pix_ready  out  1   block accepts pixel this cycle (= !fifo_full)
//  pix_rgb    in   24  pixel colour, R[23:16] G[15:8] B[7:0]
//  pix_sof    in   1   pixel is (0,0) of a new frame
//  wb_adr     out  32  byte address, word aligned
//  wb_dat_ms  out  32  {8'h00, rgb}
//  wb_sel     out  4   constant 4'b0111
//  wb_we      out  1   constant 1
//  wb_cti     out  3   constant 0 (classic cycle)
//  wb_bte     out  2   constant 0
//  wb_cyc     out  1   bus cycle request
//  wb_stb     out  1   strobe, equal to wb_cyc
//  wb_ack     in   1   write accepted by slave
//  frame_done out  1   1-cycle pulse when the last word of a frame is acked
//  busy       out  1   FSM in WRITE or FIFO not empty
// BEHAVIOUR
//  Reset, applied when rst_n is low on a clk edge:
//  - wb_cyc, wb_stb, frame_done and busy are 0; pix_ready is 1.
//  - Address register is 0, FIFO is cleared, beat count is 0, FSM is IDLE.
//  - Reset during WRITE drops cyc on the next edge; the pending word is discarded.
//  FIFO and pixel input:
//  - FIFO is first-word-fall-through; each entry is {sof, rgb}, 25 bits.
//  - A push occurs when pix_valid && pix_ready.
//  - A pop occurs only on an ack accepted in WRITE.
//  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
//    pix_ready is computed from the pre-pop count.
//  Addressing:
//  - Head address: wb_adr = head.sof ? 0 : adr_q.
//  - On each accepted ack: adr_q <= (wb_adr == LAST_ADR) ? 0 : wb_adr + 4.
//    LAST_ADR = 4*(HDISP*VDISP-1).
//  - frame_done pulses in the cycle after the ack of the word written at LAST_ADR.
//  - An sof pixel in mid-frame forces address 0 for that pixel; the partial frame is abandoned without frame_done.
//  FSM:
//  - IDLE: wb_cyc=0. Move to WRITE when the FIFO is not empty.
//  - WRITE: wb_cyc=wb_stb=1; wb_adr and wb_dat_ms come from the FIFO head and stay stable until ack.
//  - On ack in WRITE: pop, beat++.
//    - Go to IDLE if beat reaches BURST, or if the FIFO becomes empty after this pop (count==1 and no push this cycle).
//    - Otherwise stay in WRITE: back-to-back, 1 word per cycle when ack is held high.
//  - IDLE always lasts at least 1 cycle between bursts, giving the arbiter an opening. Beat resets to 0 on entry to IDLE.
//  - wb_ack while wb_stb=0 is ignored.
//  - No timeout: WRITE waits indefinitely for ack.
//  Throughput and latency:
//  - The first wb_cyc rises 2 cycles after the first push: write edge, FIFO not-empty, FSM register.
// STRUCTURE
//  fb_pkg holds:
//  - typedef pix_word_t (struct {logic sof; logic [23:0] rgb;})
//  - typedef enum {IDLE, WRITE} fbw_state_t
//  - localparam WB_SEL_RGB = 4'b0111
//  - function last_adr(hdisp, vdisp)
//  Sub-module sync_fifo #(WIDTH, AW):
//  - Single-clock FWFT FIFO with push/pop, full, empty and count.
//  - Synchronous active-low reset.
//  Top level contains the FSM, address/beat counters and Wishbone drive.
// TESTING
//  Use a Wishbone slave model with a programmable ack pattern and a shadow memory. HDISP=4, VDISP=2 unless stated.
//  1. Feed 8 pixels, sof on the first, ack always 1.
//     -> 8 writes at adr 0x00..0x1C; data {8'h00, rgb}; frame_done pulses once after adr 0x1C.
//  2. BURST=4, 8 pixels pre-filled, ack always 1.
//     -> cyc high 4 cycles, low at least 1 cycle, high 4 cycles; exactly 8 acks.
//  3. Slave inserts 3 wait states per ack.
//     -> adr and dat are stable for all 4 cycles of each write; no extra pops; the shadow memory matches the input.
//  4. Hold ack=0 and push 17 pixels with FIFO_AW=4.
//     -> pix_ready falls after 16 pushes; releasing ack drains all 16 in order; the 17th pixel is accepted once space frees.
//  5. Send 10 consecutive pixels, sof on the 1st and 6th.
//     -> 6th pixel written at adr 0, followed by 0x04..0x10; no frame_done.
//     Then a wrap test: 9 pixels with sof only on the 1st -> 9th pixel written at adr 0 after adr 0x1C.
//  6. Assert rst_n=0 for 1 cycle mid-WRITE with 5 words queued.
//     -> next cycle wb_cyc=0, busy=0, pix_ready=1; the next sof pixel is written at adr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer write master.
// Covers the pixel word layout, the FSM state type and the last-address calculation.
package fb_pkg;

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } pix_word_t;

    typedef enum logic [0:0] {IDLE, WRITE} fbw_state_t;

    localparam logic [3:0] WB_SEL_RGB = 4'b0111;
    localparam int unsigned PIX_W = 25;

    // Byte address of the final pixel of a frame.
    function automatic logic [31:0] last_adr(input int unsigned hdisp, input int unsigned vdisp);
        return 32'(4 * (hdisp * vdisp - 1));
    endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Classic Wishbone write bus between the framebuffer writer and the SDRAM controller.
interface fb_writer_if;

    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (
        output adr, dat_ms, sel, we, cti, bte, cyc, stb,
        input  ack
    );

    modport slave (
        input  adr, dat_ms, sel, we, cti, bte, cyc, stb,
        output ack
    );

endinterface

// File: rtl/fb_writer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with push/pop, full, empty and count.
module sync_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_writer.sv
// Wishbone write master that streams RGB pixels into the scan-out framebuffer.
// Pixels are queued in a FWFT FIFO and written in short classic-cycle bursts.
module fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned HDISP   = 800,
    parameter int unsigned VDISP   = 480,
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned BURST   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [23:0]        pix_rgb,
    input  logic               pix_sof,
    fb_writer_if.master        wb,
    output logic               frame_done,
    output logic               busy
);

    localparam logic [31:0] LAST_ADR = last_adr(HDISP, VDISP);
    localparam int unsigned BW       = $clog2(BURST + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [FIFO_AW:0] ONE_C  = {{FIFO_AW{1'b0}}, 1'b1};

    fbw_state_t        state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              frame_done_q, frame_done_d;

    pix_word_t         push_word;
    pix_word_t         head;
    logic [PIX_W-1:0]  head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic              push;
    logic              ack_ok;
    logic [31:0]       cur_adr;
    logic              last_word;

    assign push_word = '{sof: pix_sof, rgb: pix_rgb};
    assign pix_ready = !fifo_full;
    assign push      = pix_valid && pix_ready;
    assign ack_ok    = (state_q == WRITE) && wb.ack;
    assign head      = pix_word_t'(head_bits);
    // An sof pixel restarts the frame at address 0 even if the previous frame was incomplete.
    assign cur_adr   = head.sof ? 32'h0 : adr_q;
    // Burst also ends when this pop drains the FIFO with nothing arriving behind it.
    assign last_word = (fifo_count == ONE_C) && !push;

    sync_fifo #(
        .WIDTH (PIX_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_word),
        .pop   (ack_ok),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        beat_d       = beat_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (!fifo_empty) state_d = WRITE;
            end
            WRITE: begin
                if (ack_ok) begin
                    adr_d        = (cur_adr == LAST_ADR) ? 32'h0 : cur_adr + 32'd4;
                    frame_done_d = (cur_adr == LAST_ADR);
                    if ((beat_q == BEAT_LAST) || last_word) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            adr_q        <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            beat_q       <= beat_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wb.cyc     = (state_q == WRITE);
    assign wb.stb     = (state_q == WRITE);
    assign wb.adr     = cur_adr;
    assign wb.dat_ms  = {8'h00, head.rgb};
    assign wb.sel     = WB_SEL_RGB;
    assign wb.we      = 1'b1;
    assign wb.cti     = 3'b000;
    assign wb.bte     = 2'b00;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == WRITE) || !fifo_empty;

endmodule
